// File: rtl/mem_arbiter.sv
// Two-client round-robin arbiter in front of a dual-port RAM (one write port, one read port).
// Issues one write and one read per cycle when the two clients do not collide.
module mem_arbiter #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic              wr_enb,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              rd_enb,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data
);

  logic              prio;
  logic              conflict;
  logic              wr_go_p0;
  logic [ADDR_W-1:0] wr_addr_p0;
  logic [DATA_W-1:0] wr_data_p0;
  logic              rd_go_p0;
  logic [ADDR_W-1:0] rd_addr_p0;
  logic              rd_id_p0;
  logic              vld_p1;
  logic              id_p1;
  logic              vld_p2;
  logic              id_p2;

  // Stage p0: combinational arbitration and command selection
  always_comb begin
    conflict = req0 & req1 & ((we0 == we1) | (addr0 == addr1));
    gnt0     = rst & req0 & (~conflict | ~prio);
    gnt1     = rst & req1 & (~conflict | prio);

    wr_go_p0   = (gnt0 & we0) | (gnt1 & we1);
    wr_addr_p0 = (gnt0 & we0) ? addr0  : addr1;
    wr_data_p0 = (gnt0 & we0) ? wdata0 : wdata1;

    // A read from client 0 takes precedence in the mux; both can never be granted reads together.
    rd_go_p0   = (gnt0 & ~we0) | (gnt1 & ~we1);
    rd_addr_p0 = (gnt0 & ~we0) ? addr0 : addr1;
    rd_id_p0   = ~(gnt0 & ~we0);
  end

  // Stage p1: RAM command registers, priority update, read id enters pipeline
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prio    <= 1'b0;
      wr_enb  <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
      rd_enb  <= 1'b0;
      rd_addr <= '0;
      vld_p1  <= 1'b0;
      id_p1   <= 1'b0;
    end else begin
      if (conflict) prio <= ~prio;
      wr_enb <= wr_go_p0;
      if (wr_go_p0) begin
        wr_addr <= wr_addr_p0;
        wr_data <= wr_data_p0;
      end
      rd_enb <= rd_go_p0;
      if (rd_go_p0) rd_addr <= rd_addr_p0;
      vld_p1 <= rd_go_p0;
      id_p1  <= rd_id_p0;
    end
  end

  // Stage p2: RAM read data is valid this cycle; stage output registers capture it for the owner
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_p2  <= 1'b0;
      id_p2   <= 1'b0;
      rvalid0 <= 1'b0;
      rvalid1 <= 1'b0;
      rdata0  <= '0;
      rdata1  <= '0;
    end else begin
      vld_p2  <= vld_p1;
      id_p2   <= id_p1;
      rvalid0 <= vld_p2 & ~id_p2;
      rvalid1 <= vld_p2 & id_p2;
      if (vld_p2 & ~id_p2) rdata0 <= rd_data;
      if (vld_p2 & id_p2)  rdata1 <= rd_data;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioural 16x8 RAM (registered read, old data on collision).
module tb_mem_arbiter;
  localparam int ADDR_W = 4;
  localparam int DATA_W = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic              req0, req1, we0, we1;
  logic [ADDR_W-1:0] addr0, addr1;
  logic [DATA_W-1:0] wdata0, wdata1;
  logic              gnt0, gnt1, rvalid0, rvalid1;
  logic [DATA_W-1:0] rdata0, rdata1;
  logic              wr_enb, rd_enb;
  logic [ADDR_W-1:0] wr_addr, rd_addr;
  logic [DATA_W-1:0] wr_data, rd_data;

  logic [DATA_W-1:0] mem [16];

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (wr_enb) mem[wr_addr] <= wr_data;
    if (rd_enb) rd_data <= mem[rd_addr];
  end

  mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata0(rdata0), .rdata1(rdata1),
    .wr_enb(wr_enb), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_enb(rd_enb), .rd_addr(rd_addr), .rd_data(rd_data)
  );

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    req0 = 1'b1; req1 = 1'b1; we0 = 1'b1; we1 = 1'b1;
    addr0 = 4'd0; addr1 = 4'd1; wdata0 = 8'h12; wdata1 = 8'h34;
    #2 rst = 1'b0;
    @(negedge clk); @(negedge clk); #1;
    n_chk++; if (gnt0 !== 1'b0) $display("FAIL rst_gnt0 got %b want 0", gnt0); else n_pass++;
    n_chk++; if (gnt1 !== 1'b0) $display("FAIL rst_gnt1 got %b want 0", gnt1); else n_pass++;
    n_chk++; if (wr_enb !== 1'b0) $display("FAIL rst_wr_enb got %b want 0", wr_enb); else n_pass++;
    n_chk++; if (rd_enb !== 1'b0) $display("FAIL rst_rd_enb got %b want 0", rd_enb); else n_pass++;
    n_chk++; if (rvalid0 !== 1'b0) $display("FAIL rst_rvalid0 got %b want 0", rvalid0); else n_pass++;
    n_chk++; if (rvalid1 !== 1'b0) $display("FAIL rst_rvalid1 got %b want 0", rvalid1); else n_pass++;
    n_chk++; if (wr_addr !== 4'd0) $display("FAIL rst_wr_addr got %0h want 0", wr_addr); else n_pass++;
    n_chk++; if (wr_data !== 8'h00) $display("FAIL rst_wr_data got %0h want 0", wr_data); else n_pass++;
    n_chk++; if (rd_addr !== 4'd0) $display("FAIL rst_rd_addr got %0h want 0", rd_addr); else n_pass++;
    n_chk++; if (rdata0 !== 8'h00) $display("FAIL rst_rdata0 got %0h want 0", rdata0); else n_pass++;
    n_chk++; if (rdata1 !== 8'h00) $display("FAIL rst_rdata1 got %0h want 0", rdata1); else n_pass++;
    rst = 1'b1; #1;
    n_chk++; if (gnt0 !== 1'b1) $display("FAIL rel_gnt0 got %b want 1", gnt0); else n_pass++;
    n_chk++; if (gnt1 !== 1'b0) $display("FAIL rel_gnt1 got %b want 0", gnt1); else n_pass++;
    req0 = 1'b0; req1 = 1'b0;
    tick();
  endtask

  task automatic test_single();
    req0 = 1'b1; we0 = 1'b1; addr0 = 4'd3; wdata0 = 8'hA5; req1 = 1'b0; #1;
    n_chk++; if (gnt0 !== 1'b1) $display("FAIL single_wr_gnt0 got %b want 1", gnt0); else n_pass++;
    n_chk++; if (gnt1 !== 1'b0) $display("FAIL single_wr_gnt1 got %b want 0", gnt1); else n_pass++;
    tick();
    n_chk++; if (wr_enb !== 1'b1) $display("FAIL single_wr_enb got %b want 1", wr_enb); else n_pass++;
    n_chk++; if (wr_addr !== 4'd3) $display("FAIL single_wr_addr got %0h want 3", wr_addr); else n_pass++;
    n_chk++; if (wr_data !== 8'hA5) $display("FAIL single_wr_data got %0h want a5", wr_data); else n_pass++;
    n_chk++; if (rd_enb !== 1'b0) $display("FAIL single_wr_rd_enb got %b want 0", rd_enb); else n_pass++;
    we0 = 1'b0; #1;
    n_chk++; if (gnt0 !== 1'b1) $display("FAIL single_rd_gnt0 got %b want 1", gnt0); else n_pass++;
    tick();
    req0 = 1'b0;
    n_chk++; if (rd_enb !== 1'b1) $display("FAIL single_rd_enb got %b want 1", rd_enb); else n_pass++;
    n_chk++; if (rd_addr !== 4'd3) $display("FAIL single_rd_addr got %0h want 3", rd_addr); else n_pass++;
    n_chk++; if (wr_enb !== 1'b0) $display("FAIL single_rd_wr_enb got %b want 0", wr_enb); else n_pass++;
    tick();
    n_chk++; if (rvalid0 !== 1'b0) $display("FAIL single_early_rvalid0 got %b want 0", rvalid0); else n_pass++;
    tick();
    n_chk++; if (rvalid0 !== 1'b1) $display("FAIL single_rvalid0 got %b want 1", rvalid0); else n_pass++;
    n_chk++; if (rdata0 !== 8'hA5) $display("FAIL single_rdata0 got %0h want a5", rdata0); else n_pass++;
    n_chk++; if (rvalid1 !== 1'b0) $display("FAIL single_rvalid1 got %b want 0", rvalid1); else n_pass++;
    tick();
    n_chk++; if (rvalid0 !== 1'b0) $display("FAIL single_rvalid0_drop got %b want 0", rvalid0); else n_pass++;
  endtask

  task automatic test_dual_issue();
    req1 = 1'b1; we1 = 1'b1; addr1 = 4'd7; wdata1 = 8'h77;
    tick();
    req0 = 1'b1; we0 = 1'b1; addr0 = 4'd2; wdata0 = 8'h11;
    req1 = 1'b1; we1 = 1'b0; addr1 = 4'd7; #1;
    n_chk++; if (gnt0 !== 1'b1) $display("FAIL dual_gnt0 got %b want 1", gnt0); else n_pass++;
    n_chk++; if (gnt1 !== 1'b1) $display("FAIL dual_gnt1 got %b want 1", gnt1); else n_pass++;
    tick();
    req0 = 1'b0; req1 = 1'b0;
    n_chk++; if (wr_enb !== 1'b1) $display("FAIL dual_wr_enb got %b want 1", wr_enb); else n_pass++;
    n_chk++; if (wr_addr !== 4'd2) $display("FAIL dual_wr_addr got %0h want 2", wr_addr); else n_pass++;
    n_chk++; if (wr_data !== 8'h11) $display("FAIL dual_wr_data got %0h want 11", wr_data); else n_pass++;
    n_chk++; if (rd_enb !== 1'b1) $display("FAIL dual_rd_enb got %b want 1", rd_enb); else n_pass++;
    n_chk++; if (rd_addr !== 4'd7) $display("FAIL dual_rd_addr got %0h want 7", rd_addr); else n_pass++;
    tick();
    n_chk++; if (rvalid1 !== 1'b0) $display("FAIL dual_early_rvalid1 got %b want 0", rvalid1); else n_pass++;
    tick();
    n_chk++; if (rvalid1 !== 1'b1) $display("FAIL dual_rvalid1 got %b want 1", rvalid1); else n_pass++;
    n_chk++; if (rdata1 !== 8'h77) $display("FAIL dual_rdata1 got %0h want 77", rdata1); else n_pass++;
    n_chk++; if (rvalid0 !== 1'b0) $display("FAIL dual_rvalid0 got %b want 0", rvalid0); else n_pass++;
    // prio must still favour client 0
    req0 = 1'b1; req1 = 1'b1; we0 = 1'b0; we1 = 1'b0; addr0 = 4'd0; addr1 = 4'd1; #1;
    n_chk++; if (gnt0 !== 1'b1) $display("FAIL dual_prio_gnt0 got %b want 1", gnt0); else n_pass++;
    n_chk++; if (gnt1 !== 1'b0) $display("FAIL dual_prio_gnt1 got %b want 0", gnt1); else n_pass++;
    req0 = 1'b0; req1 = 1'b0;
    tick();
  endtask

  task automatic test_write_contention();
    logic [DATA_W-1:0] exp_d [6];
    logic              exp_g0, exp_g1;
    int                idx0, idx1;
    exp_d = '{8'hA0, 8'hB1, 8'hA2, 8'hB3, 8'hA4, 8'hB5};
    idx0 = 0; idx1 = 0;
    for (int i = 0; i < 6; i++) begin
      req0 = (idx0 < 3); we0 = 1'b1; addr0 = ADDR_W'(2 * idx0);     wdata0 = DATA_W'(8'hA0 + 2 * idx0);
      req1 = (idx1 < 3); we1 = 1'b1; addr1 = ADDR_W'(2 * idx1 + 1); wdata1 = DATA_W'(8'hB1 + 2 * idx1);
      exp_g0 = (i % 2 == 0); exp_g1 = (i % 2 == 1); #1;
      n_chk++; if (gnt0 !== exp_g0) $display("FAIL wc_gnt0[%0d] got %b want %b", i, gnt0, exp_g0); else n_pass++;
      n_chk++; if (gnt1 !== exp_g1) $display("FAIL wc_gnt1[%0d] got %b want %b", i, gnt1, exp_g1); else n_pass++;
      tick();
      n_chk++; if (wr_enb !== 1'b1) $display("FAIL wc_wr_enb[%0d] got %b want 1", i, wr_enb); else n_pass++;
      n_chk++; if (wr_addr !== ADDR_W'(i)) $display("FAIL wc_wr_addr[%0d] got %0h want %0h", i, wr_addr, i); else n_pass++;
      n_chk++; if (wr_data !== exp_d[i]) $display("FAIL wc_wr_data[%0d] got %0h want %0h", i, wr_data, exp_d[i]); else n_pass++;
      if (i % 2 == 0) idx0++; else idx1++;
    end
    req0 = 1'b0; req1 = 1'b0;
    // back-to-back readback of addresses 0..5 by client 0
    for (int c = 0; c < 8; c++) begin
      if (c < 6) begin
        req0 = 1'b1; we0 = 1'b0; addr0 = ADDR_W'(c);
      end else begin
        req0 = 1'b0;
      end
      tick();
      if (c >= 2) begin
        n_chk++; if (rvalid0 !== 1'b1) $display("FAIL rb_rvalid0[%0d] got %b want 1", c - 2, rvalid0); else n_pass++;
        n_chk++; if (rdata0 !== exp_d[c-2]) $display("FAIL rb_rdata0[%0d] got %0h want %0h", c - 2, rdata0, exp_d[c-2]); else n_pass++;
        n_chk++; if (rvalid1 !== 1'b0) $display("FAIL rb_rvalid1[%0d] got %b want 0", c - 2, rvalid1); else n_pass++;
      end
    end
  endtask

  task automatic test_address_hazard();
    // prio is 1 here: five conflicting edges in the contention run
    req0 = 1'b1; we0 = 1'b1; addr0 = 4'd4; wdata0 = 8'h00;
    tick();
    req0 = 1'b1; we0 = 1'b1; addr0 = 4'd4; wdata0 = 8'h3C;
    req1 = 1'b1; we1 = 1'b0; addr1 = 4'd4; #1;
    n_chk++; if (gnt1 !== 1'b1) $display("FAIL hz_gnt1 got %b want 1", gnt1); else n_pass++;
    n_chk++; if (gnt0 !== 1'b0) $display("FAIL hz_gnt0 got %b want 0", gnt0); else n_pass++;
    tick();
    req1 = 1'b0; #1;
    n_chk++; if (gnt0 !== 1'b1) $display("FAIL hz_gnt0_next got %b want 1", gnt0); else n_pass++;
    n_chk++; if (rd_enb !== 1'b1) $display("FAIL hz_rd_enb got %b want 1", rd_enb); else n_pass++;
    n_chk++; if (wr_enb !== 1'b0) $display("FAIL hz_wr_enb_early got %b want 0", wr_enb); else n_pass++;
    tick();
    req0 = 1'b0;
    n_chk++; if (wr_enb !== 1'b1) $display("FAIL hz_wr_enb got %b want 1", wr_enb); else n_pass++;
    n_chk++; if (wr_data !== 8'h3C) $display("FAIL hz_wr_data got %0h want 3c", wr_data); else n_pass++;
    tick();
    n_chk++; if (rvalid1 !== 1'b1) $display("FAIL hz_rvalid1 got %b want 1", rvalid1); else n_pass++;
    n_chk++; if (rdata1 !== 8'h00) $display("FAIL hz_old_rdata1 got %0h want 0", rdata1); else n_pass++;
    req1 = 1'b1; we1 = 1'b0; addr1 = 4'd4;
    tick();
    req1 = 1'b0;
    tick(); tick();
    n_chk++; if (rvalid1 !== 1'b1) $display("FAIL hz_reread_rvalid1 got %b want 1", rvalid1); else n_pass++;
    n_chk++; if (rdata1 !== 8'h3C) $display("FAIL hz_new_rdata1 got %0h want 3c", rdata1); else n_pass++;
  endtask

  task automatic test_reset_mid_read();
    // prio is 0 here; one conflicting write moves it to 1
    req0 = 1'b1; we0 = 1'b1; addr0 = 4'd8; wdata0 = 8'h5A;
    req1 = 1'b1; we1 = 1'b1; addr1 = 4'd9; wdata1 = 8'h5B; #1;
    n_chk++; if (gnt0 !== 1'b1) $display("FAIL mr_gnt0 got %b want 1", gnt0); else n_pass++;
    tick();
    req0 = 1'b1; we0 = 1'b1; addr0 = 4'd10; wdata0 = 8'h5C;
    req1 = 1'b1; we1 = 1'b0; addr1 = 4'd4;
    tick();
    req0 = 1'b0; req1 = 1'b0;
    n_chk++; if (rd_enb !== 1'b1) $display("FAIL mr_rd_enb_pre got %b want 1", rd_enb); else n_pass++;
    n_chk++; if (wr_enb !== 1'b1) $display("FAIL mr_wr_enb_pre got %b want 1", wr_enb); else n_pass++;
    rst = 1'b0; #1;
    n_chk++; if (rd_enb !== 1'b0) $display("FAIL mr_rd_enb got %b want 0", rd_enb); else n_pass++;
    n_chk++; if (wr_enb !== 1'b0) $display("FAIL mr_wr_enb got %b want 0", wr_enb); else n_pass++;
    n_chk++; if (wr_addr !== 4'd0) $display("FAIL mr_wr_addr got %0h want 0", wr_addr); else n_pass++;
    for (int k = 0; k < 2; k++) begin
      tick();
      n_chk++; if (rvalid1 !== 1'b0) $display("FAIL mr_rvalid1_in_rst[%0d] got %b want 0", k, rvalid1); else n_pass++;
    end
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      n_chk++; if (rvalid1 !== 1'b0) $display("FAIL mr_rvalid1_after[%0d] got %b want 0", k, rvalid1); else n_pass++;
    end
    req0 = 1'b1; req1 = 1'b1; we0 = 1'b1; we1 = 1'b1; addr0 = 4'd0; addr1 = 4'd1; #1;
    n_chk++; if (gnt0 !== 1'b1) $display("FAIL mr_prio_gnt0 got %b want 1", gnt0); else n_pass++;
    n_chk++; if (gnt1 !== 1'b0) $display("FAIL mr_prio_gnt1 got %b want 0", gnt1); else n_pass++;
    req0 = 1'b0; req1 = 1'b0;
    tick();
  endtask

  initial begin
    rst = 1'b1;
    req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
    test_reset();
    test_single();
    test_dual_issue();
    test_write_contention();
    test_address_hazard();
    test_reset_mid_read();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
